// File: rtl/display_scan_ctrl_if.sv
// Display scan bus: digit source inputs, decoder loop (bcd_out/seg_in), pin drive.
interface display_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic                blank_lz;
  logic                blink_req;
  logic [3:0]          bcd_out;
  logic [6:0]          seg_in;
  logic [6:0]          seg_out;
  logic [DIGITS-1:0]   an_out;
  logic                frame_tick;

  modport master (
    output digits_in, blank_lz, blink_req, seg_in,
    input  bcd_out, seg_out, an_out, frame_tick
  );

  modport slave (
    input  digits_in, blank_lz, blink_req, seg_in,
    output bcd_out, seg_out, an_out, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame snapshot,
// leading-zero blanking and dead-time between digit slots.
// Optional whole-display blink: define DISPLAY_BLINK_EN.
module display_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap;
  logic [DIGITS-1:0]   mask;
  logic [DIGITS-1:0]   mask_next_c;
  logic [3:0]          cur_digit_c;
  logic                frame_start_c;
  logic                show_blank_c;
  logic                frame_on_c;

  logic [3:0]          bcd_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   an_q;
  logic                tick_q;

  assign frame_start_c  = (pre == '0) && (idx == '0);
  assign bus.bcd_out    = bcd_q;
  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.frame_tick = tick_q;

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Leading-zero mask from the incoming digits; digit 0 never masked
  always_comb begin
    logic run;
    mask_next_c = '0;
    run         = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run            = run & (bus.digits_in[4*k +: 4] == 4'd0);
      mask_next_c[k] = run & bus.blank_lz;
    end
  end

  // Frame snapshot of digits and mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      mask <= '0;
    end else if (frame_start_c) begin
      snap <= bus.digits_in;
      mask <= mask_next_c;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          phase_on;
  logic          frame_on;

  // Blink phase advanced per frame; frame_on is the phase applied to this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      frame_on  <= 1'b1;
    end else if (frame_start_c) begin
      frame_on <= ~bus.blink_req | phase_on;
      if (!bus.blink_req) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign frame_on_c = frame_on;
`else
  logic unused_blink;

  assign frame_on_c   = 1'b1;
  assign unused_blink = bus.blink_req ^ (BLINK_FRAMES == 0);
`endif

  // Digit presented to the decoder; at frame start the fresh digit bypasses the snapshot
  always_comb begin
    cur_digit_c = snap[{idx, 2'b00} +: 4];
    if (frame_start_c) cur_digit_c = bus.digits_in[3:0];
  end

  // Blank when masked, invalid BCD, or blink phase off
  assign show_blank_c = mask[idx] | (bcd_q > 4'd9) | ~frame_on_c;

  // Registered display outputs: slot cycle 0 loads digit with dead time, cycle 1 lights it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      seg_q  <= '0;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      tick_q <= frame_start_c;
      if (pre == '0) begin
        bcd_q <= cur_digit_c;
        an_q  <= '1;
      end else if (pre == PRE_W'(1)) begin
        seg_q <= show_blank_c ? 7'd0 : bus.seg_in;
        an_q  <= frame_on_c ? ~(DIGITS'(1) << idx) : '1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (DIGITS=4, SCAN_DIV=4) with a decoder model.
module tb_display_scan_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  display_scan_ctrl_if #(.DIGITS(4)) bus ();

  display_scan_ctrl #(
    .DIGITS      (4),
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Seven-segment decoder {a..g}, active-high
  function automatic logic [6:0] dec7(input logic [3:0] b);
    case (b)
      4'd0:    dec7 = 7'd126;
      4'd1:    dec7 = 7'd48;
      4'd2:    dec7 = 7'd109;
      4'd3:    dec7 = 7'd121;
      4'd4:    dec7 = 7'd51;
      4'd5:    dec7 = 7'd91;
      4'd6:    dec7 = 7'd95;
      4'd7:    dec7 = 7'd112;
      4'd8:    dec7 = 7'd127;
      4'd9:    dec7 = 7'd123;
      4'd10:   dec7 = 7'd119;
      default: dec7 = 7'd79;
    endcase
  endfunction

  assign bus.seg_in = dec7(bus.bcd_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge where frame_tick is seen; n = edges waited
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 40);
    if (!bus.frame_tick) check("tick_timeout", 32'(bus.frame_tick), 32'd1);
  endtask

  // One frame: dead time then lit digit per slot; optional mid-frame input change
  task automatic chk_frame(input string tag, input logic [27:0] segs, input logic [15:0] ans,
                           input logic [15:0] bcds, input logic chg, input logic [15:0] nd);
    int n;
    wait_tick(n);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (3) @(negedge clk);
      check({tag, "_dead"}, 32'(bus.an_out), 32'hF);
      if (chg && k == 1) bus.digits_in = nd;
      @(negedge clk);
      check({tag, "_seg"}, 32'(bus.seg_out), 32'(segs[7*k +: 7]));
      check({tag, "_an"},  32'(bus.an_out),  32'(ans[4*k +: 4]));
      check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(bcds[4*k +: 4]));
    end
  endtask

  localparam logic [15:0] AN_SCAN = 16'h7BDE;
  localparam logic [15:0] AN_OFF  = 16'hFFFF;

  initial begin
    int n;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.digits_in = 16'h1259;
    bus.blank_lz  = 1'b0;
    bus.blink_req = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_seg",  32'(bus.seg_out),    32'd0);
    check("rst_an",   32'(bus.an_out),     32'hF);
    check("rst_bcd",  32'(bus.bcd_out),    32'd0);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);

    // First edge after release is a frame start
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_lat", 32'(n), 32'd1);
    repeat (2) @(negedge clk);
    check("first_seg", 32'(bus.seg_out), 32'd123);

    chk_frame("t1", {7'd48, 7'd109, 7'd91, 7'd123}, AN_SCAN, 16'h1259, 1'b0, 16'h0);
    wait_tick(n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 40);
    check("tick_period", 32'(n), 32'd16);

    // Leading-zero blanking
    bus.digits_in = 16'h0005;
    bus.blank_lz  = 1'b1;
    chk_frame("t2_lz", {7'd0, 7'd0, 7'd0, 7'd91}, AN_SCAN, 16'h0005, 1'b0, 16'h0);
    bus.blank_lz = 1'b0;
    chk_frame("t2_nolz", {7'd126, 7'd126, 7'd126, 7'd91}, AN_SCAN, 16'h0005, 1'b0, 16'h0);

    // All zeros: digit 0 stays lit
    bus.digits_in = 16'h0000;
    bus.blank_lz  = 1'b1;
    chk_frame("t3", {7'd0, 7'd0, 7'd0, 7'd126}, AN_SCAN, 16'h0000, 1'b0, 16'h0);

    // Mid-frame change is deferred to the next frame
    bus.digits_in = 16'h0800;
    bus.blank_lz  = 1'b0;
    chk_frame("t4_old", {7'd126, 7'd127, 7'd126, 7'd126}, AN_SCAN, 16'h0800, 1'b1, 16'h0900);
    chk_frame("t4_new", {7'd126, 7'd123, 7'd126, 7'd126}, AN_SCAN, 16'h0900, 1'b0, 16'h0);

    // Invalid BCD presented but blanked
    bus.digits_in = 16'h00A3;
    chk_frame("t5", {7'd126, 7'd126, 7'd0, 7'd121}, AN_SCAN, 16'h00A3, 1'b0, 16'h0);

    // Blink
    bus.digits_in = 16'h1259;
    bus.blink_req = 1'b1;
    chk_frame("t6_f1", {7'd48, 7'd109, 7'd91, 7'd123}, AN_SCAN, 16'h1259, 1'b0, 16'h0);
    chk_frame("t6_f2", {7'd48, 7'd109, 7'd91, 7'd123}, AN_SCAN, 16'h1259, 1'b0, 16'h0);
`ifdef DISPLAY_BLINK_EN
    chk_frame("t6_f3", 28'd0, AN_OFF, 16'h1259, 1'b0, 16'h0);
`else
    chk_frame("t6_f3", {7'd48, 7'd109, 7'd91, 7'd123}, AN_SCAN, 16'h1259, 1'b0, 16'h0);
`endif
    bus.blink_req = 1'b0;
    chk_frame("t6_f4", {7'd48, 7'd109, 7'd91, 7'd123}, AN_SCAN, 16'h1259, 1'b0, 16'h0);

    // Asynchronous reset mid-slot, then restart at digit 0
    wait_tick(n);
    repeat (5) @(negedge clk);
    check("pre_rst_an", 32'(bus.an_out), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an",  32'(bus.an_out),  32'hF);
    check("arst_seg", 32'(bus.seg_out), 32'd0);
    check("arst_bcd", 32'(bus.bcd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    check("restart_tick_lat", 32'(n), 32'd1);
    @(negedge clk);
    check("restart_an",  32'(bus.an_out),  32'hE);
    check("restart_seg", 32'(bus.seg_out), 32'd123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
